// File: rtl/ascii_line_buffer.sv
// ascii_line_buffer: collects ASCII keystrokes into a fixed-width line.
// Printable bytes are appended, backspace blanks the last cell, enter
// freezes the line until the consumer acknowledges it, after which every
// cell is blanked to a space before new input is taken.
//
// state  | meaning
// CLEAR  | blanking cells 0..DEPTH-1 to 0x20, one per cycle; no input taken
// ACCEPT | taking keyboard bytes, editing the line
// DONE   | line terminated by enter, held until line_ack
module ascii_line_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          line_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   len,
    output logic          line_done,
    output logic          overflow
);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        ACCEPT = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [7:0]    SPACE    = 8'h20;
    localparam logic [7:0]    BKSP     = 8'h08;
    localparam logic [7:0]    ENTER    = 8'h0D;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [7:0]    mem [DEPTH];

    logic          take;
    logic          printable;
    logic          is_bksp;
    logic          is_enter;
    logic          has_room;
    logic          not_empty;
    logic [AW:0]   len_m1;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    assign take      = in_valid & in_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign is_bksp   = (in_data == BKSP);
    assign is_enter  = (in_data == ENTER);
    assign has_room  = (len < FULL);
    assign not_empty = (len != '0);
    assign len_m1    = len - (AW+1)'(1);

    // Single buffer write port: clear pointer in CLEAR, edit position in ACCEPT.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = SPACE;
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = ptr;
            end
            ACCEPT: begin
                if (take && printable && has_room) begin
                    wr_en   = 1'b1;
                    wr_addr = len[AW-1:0];
                    wr_data = in_data;
                end else if (take && is_bksp && not_empty) begin
                    wr_en   = 1'b1;
                    wr_addr = len_m1[AW-1:0];
                end
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Buffer storage; no write lands on the edge where reset is sampled.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered display read; sees the pre-write contents of a cell written on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    // Line-editing FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            ptr       <= '0;
            len       <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
            line_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state    <= ACCEPT;
                        in_ready <= 1'b1;
                        len      <= '0;
                        overflow <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (take) begin
                        if (printable) begin
                            if (has_room) begin
                                len <= len + 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (is_bksp) begin
                            if (not_empty) begin
                                len <= len_m1;
                            end
                        end else if (is_enter) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            line_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (line_ack) begin
                        state     <= CLEAR;
                        ptr       <= '0;
                        line_done <= 1'b0;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    ptr       <= '0;
                    in_ready  <= 1'b0;
                    line_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_line_buffer.sv
// Testbench for ascii_line_buffer: directed and random keystroke streams
// compared against a queue-based model of the edited line.
module tb_ascii_line_buffer;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          line_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW:0]   len;
    logic          line_done;
    logic          overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // model: the line is just the list of characters typed so far
    logic [7:0] mline[$];
    bit         movf;
    bit         mdone;

    ascii_line_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .line_ack  (line_ack),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .len       (len),
        .line_done (line_done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_cell(input int i);
        if (i < mline.size()) return mline[i];
        return 8'h20;
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (mline.size() < DEPTH) mline.push_back(b);
            else movf = 1'b1;
        end else if (b == 8'h08) begin
            if (mline.size() > 0) void'(mline.pop_back());
        end else if (b == 8'h0D) begin
            mdone = 1'b1;
        end
    endfunction

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 500) begin
            tick();
            cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int c;
        wait_ready(c);
        chk("ready_before_send", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        model_apply(b);
        if (b != 8'h0D) chk("ready_after_send", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_len"},       32'(len),       32'(mline.size()));
        chk({tag, "_overflow"},  32'(overflow),  32'(movf));
        chk({tag, "_line_done"}, 32'(line_done), 32'(mdone));
        chk({tag, "_in_ready"},  32'(in_ready),  32'(!mdone));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            tick();
            chk($sformatf("%s_cell%0d", tag, i), 32'(rd_data), 32'(model_cell(i)));
        end
    endtask

    task automatic model_clear();
        mline.delete();
        movf  = 1'b0;
        mdone = 1'b0;
    endtask

    task automatic end_line(input string tag);
        int c;
        send_byte(8'h0D);
        check_state({tag, "_done"});
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
        chk({tag, "_ack_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_ack_done"},  32'(line_done), 32'd0);
        wait_ready(c);
        chk({tag, "_clear_cycles"}, 32'(c), 32'(DEPTH));
        model_clear();
        check_state({tag, "_cleared"});
    endtask

    logic [7:0] others [6];

    initial begin
        int c;
        logic [7:0] b;
        others[0] = 8'h00; others[1] = 8'h1B; others[2] = 8'h7F;
        others[3] = 8'h80; others[4] = 8'hFF; others[5] = 8'h0A;
        model_clear();

        // reset with in_valid held high throughout
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h00; line_ack = 1'b0; rd_addr = '0;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        chk("rst_len",       32'(len),       32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_rd_data",   32'(rd_data),   32'd0);
        rst = 1'b0;
        wait_ready(c);
        chk("init_clear_cycles", 32'(c), 32'(DEPTH));
        in_valid = 1'b0;
        check_state("init");
        read_all("init");

        // line_ack outside DONE is ignored
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
        tick();
        check_state("ack_ignored");

        // H I enter
        send_byte(8'h48);
        send_byte(8'h49);
        send_byte(8'h0D);
        check_state("hi");
        read_all("hi");
        // DONE ignores input
        in_valid = 1'b1; in_data = 8'h41;
        tick(); tick();
        in_valid = 1'b0;
        check_state("hi_hold");
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
        wait_ready(c);
        chk("hi_clear_cycles", 32'(c), 32'(DEPTH));
        model_clear();
        check_state("hi_cleared");
        read_all("hi_cleared");

        // backspace editing
        send_byte(8'h41);
        send_byte(8'h08);
        send_byte(8'h08);
        send_byte(8'h42);
        check_state("bksp");
        read_all("bksp");

        // read-before-write on the cell being appended
        rd_addr = AW'(1);
        send_byte(8'h43);
        chk("rbw_old", 32'(rd_data), 32'h20);
        tick();
        chk("rbw_new", 32'(rd_data), 32'h43);
        end_line("bksp");

        // overflow with 33 bytes
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h78);
        check_state("ovf");
        read_all("ovf");
        end_line("ovf");

        // codes with no effect
        send_byte(8'h61);
        send_byte(8'h1B);
        check_state("esc");
        send_byte(8'h80);
        check_state("hi_bit");
        read_all("other");
        end_line("other");

        // random lines
        for (int l = 0; l < 6; l++) begin
            int n;
            n = $urandom_range(0, 45);
            for (int k = 0; k < n; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r <= 5 || r == 9) b = 8'($urandom_range(32, 126));
                else if (r <= 7)      b = 8'h08;
                else                  b = others[$urandom_range(0, 5)];
                send_byte(b);
            end
            check_state($sformatf("rnd%0d", l));
            read_all($sformatf("rnd%0d", l));
            end_line($sformatf("rnd%0d", l));
        end

        // reset while in DONE with five characters
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        send_byte(8'h0D);
        check_state("pre_rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("drst_line_done", 32'(line_done), 32'd0);
        chk("drst_len",       32'(len),       32'd0);
        chk("drst_in_ready",  32'(in_ready),  32'd0);
        wait_ready(c);
        chk("drst_clear_cycles", 32'(c), 32'(DEPTH));
        check_state("drst");
        read_all("drst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii_line_buffer.md
ASCII_LINE_BUFFER -- requirements
Module: ascii_line_buffer

Interface
REQ-001 Parameter: DEPTH, 32, number of character cells in the line (power of two, 8..64).
REQ-002 Parameter: AW, 5, address width, equal to log2(DEPTH).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  an ASCII byte from the keyboard decoder is offered.
REQ-006 Port: in_data  input  8  offered ASCII code.
REQ-007 Port: in_ready  output  1  the block accepts a byte this cycle.
REQ-008 Port: line_ack  input  1  consumer has taken the completed line.
REQ-009 Port: rd_addr  input  AW  display read address.
REQ-010 Port: rd_data  output  8  buffer content at rd_addr, registered.
REQ-011 Port: len  output  AW+1  number of characters currently in the line, 0..DEPTH.
REQ-012 Port: line_done  output  1  a line is terminated and held for the consumer.
REQ-013 Port: overflow  output  1  sticky: at least one printable byte was dropped because the line was full.

Function
REQ-014 The block is an FSM with states CLEAR, ACCEPT and DONE.
REQ-015 in_ready is 1 only in ACCEPT; a transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-016 Printable byte (0x20..0x7E) with len<DEPTH: buf[len] <= byte and len <= len+1.
REQ-017 Printable byte with len==DEPTH: the byte is dropped, len is unchanged and overflow <= 1.
REQ-018 Backspace (0x08) with len>0: len <= len-1 and buf[len-1] <= 0x20; with len==0 the byte is ignored.
REQ-019 Enter (0x0D): the buffer is unchanged and the next state is DONE; line_done is 1 from the following cycle.
REQ-020 Any other code is consumed (in_ready stays 1) with no effect on the buffer, len or overflow.
REQ-021 In DONE: in_ready=0 and line_done=1; len, the buffer and overflow are held; the block stays in DONE until line_ack=1.
REQ-022 line_ack=1 in DONE moves the block to CLEAR on the next edge; line_ack in CLEAR or ACCEPT is ignored.
REQ-023 In CLEAR: in_ready=0 and line_done=0; an internal pointer writes 0x20 to cells 0..DEPTH-1, one cell per cycle (DEPTH cycles).
REQ-024 After the write to cell DEPTH-1, the block enters ACCEPT with len=0 and overflow=0.
REQ-025 rd_data <= buf[rd_addr] on every edge in every state (1-cycle latency).
REQ-026 A write and a read of the same cell on the same edge return the old contents (read-before-write).
REQ-027 in_ready and line_done are decoded directly from the state register, with no combinational path from in_valid or line_ack.
REQ-028 len arithmetic is AW+1 bits wide and never wraps: it saturates at DEPTH and floors at 0.

Reset
REQ-029 rst=1 on a clock edge forces state CLEAR, clear pointer=0, len=0, overflow=0 and rd_data=0x00.
REQ-030 Reset asserted mid-line or in DONE discards the line; the full DEPTH-cycle clear runs again after rst falls.
REQ-031 Outputs during and after reset: in_ready=0 and line_done=0 until the clear sequence completes.

Verification
REQ-032 Release reset and hold in_valid=1 -> in_ready rises exactly DEPTH cycles later; reading every address returns 0x20.
REQ-033 Send 'H','I',0x0D -> len=2, rd_data at addr 0 is 0x48 and at addr 1 is 0x49, line_done=1, in_ready=0; pulse line_ack -> after DEPTH cycles len=0 and in_ready=1.
REQ-034 Send 'A',0x08,0x08,'B' -> len=1, addr 0 reads 0x42, addr 1 reads 0x20, overflow=0.
REQ-035 Send 33 times 'x' with DEPTH=32 -> len=32, overflow=1, in_ready stays 1; the 33rd byte is not stored.
REQ-036 Send 0x1B and 0x80 -> each is accepted in one cycle, len unchanged, no buffer change.
REQ-037 Assert rst for one cycle while in DONE with len=5 -> line_done=0, len=0, in_ready=0 for DEPTH cycles, then 1.
